// File: rtl/digdug_hvgen.sv
// Raster timing generator for the DigDug video stage: pixel enable, POSH/POSV scan
// counters, blanking/sync decoded from the next counter values, vblank IRQ and frame count.
module digdug_hvgen #(
    parameter int CLK_DIV  = 8,
    parameter int H_BASE   = 128,
    parameter int V_TOTAL  = 264,
    parameter int HBLK_OFF = 144,
    parameter int HBLK_ON  = 432,
    parameter int HS_ON    = 448,
    parameter int HS_OFF   = 480,
    parameter int VBLK_ON  = 224,
    parameter int VS_ON    = 240,
    parameter int VS_OFF   = 244
) (
    input  logic       CLK48M,
    input  logic       RESET_N,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    output logic       PCLK_EN,
    output logic [8:0] POSH,
    output logic [8:0] POSV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VBIRQ,
    output logic [7:0] FRAME
);

    localparam logic [2:0] DIV_LAST   = 3'(CLK_DIV - 1);
    localparam logic [8:0] H_BASE_9   = 9'(H_BASE);
    localparam logic [8:0] H_LAST_9   = 9'd511;
    localparam logic [8:0] V_LAST_9   = 9'(V_TOTAL - 1);
    localparam logic [8:0] HBLK_OFF_9 = 9'(HBLK_OFF);
    localparam logic [8:0] HBLK_ON_9  = 9'(HBLK_ON);
    localparam logic [8:0] HS_ON_9    = 9'(HS_ON);
    localparam logic [8:0] HS_OFF_9   = 9'(HS_OFF);
    localparam logic [8:0] VBLK_ON_9  = 9'(VBLK_ON);
    localparam logic [8:0] VBIRQ_PRE  = 9'(VBLK_ON - 1);
    localparam logic [8:0] VS_ON_9    = 9'(VS_ON);
    localparam logic [8:0] VS_OFF_9   = 9'(VS_OFF);

    logic [2:0] div_q,   div_d;
    logic       pclk_en_q, pclk_en_d;
    logic [8:0] posh_q,  posh_d;
    logic [8:0] posv_q,  posv_d;
    logic       hblk_q,  hblk_d;
    logic       vblk_q,  vblk_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vbirq_q, vbirq_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] hofs_q,  hofs_d;
    logic [3:0] vofs_q,  vofs_d;

    logic       line_end;
    logic       frame_end;
    logic [8:0] posh_nx;
    logic [8:0] posv_nx;
    logic [8:0] hs_on_sh;
    logic [8:0] hs_off_sh;
    logic [8:0] vs_on_sh;
    logic [8:0] vs_off_sh;

    // Next-position values and the offset windows that will apply to them.
    always_comb begin
        line_end  = (posh_q == H_LAST_9);
        frame_end = line_end && (posv_q == V_LAST_9);
        posh_nx   = line_end ? H_BASE_9 : posh_q + 9'd1;
        if (frame_end) begin
            posv_nx = 9'd0;
        end else if (line_end) begin
            posv_nx = posv_q + 9'd1;
        end else begin
            posv_nx = posv_q;
        end
        // Offsets are only taken at frame start so a sync pulse is never cut short.
        hofs_d    = (pclk_en_q && frame_end) ? HOFS : hofs_q;
        vofs_d    = (pclk_en_q && frame_end) ? VOFS : vofs_q;
        hs_on_sh  = HS_ON_9  + {{5{hofs_d[3]}}, hofs_d};
        hs_off_sh = HS_OFF_9 + {{5{hofs_d[3]}}, hofs_d};
        vs_on_sh  = VS_ON_9  + {{5{vofs_d[3]}}, vofs_d};
        vs_off_sh = VS_OFF_9 + {{5{vofs_d[3]}}, vofs_d};
    end

    always_comb begin
        div_d     = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
        pclk_en_d = (div_q == DIV_LAST);
        posh_d    = posh_q;
        posv_d    = posv_q;
        hblk_d    = hblk_q;
        vblk_d    = vblk_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        frame_d   = frame_q;
        vbirq_d   = 1'b0;
        if (pclk_en_q) begin
            posh_d  = posh_nx;
            posv_d  = posv_nx;
            hblk_d  = (posh_nx >= HBLK_ON_9) || (posh_nx < HBLK_OFF_9);
            vblk_d  = (posv_nx >= VBLK_ON_9);
            hsync_d = (posh_nx >= hs_on_sh) && (posh_nx < hs_off_sh);
            vsync_d = (posv_nx >= vs_on_sh) && (posv_nx < vs_off_sh);
            vbirq_d = line_end && (posv_q == VBIRQ_PRE);
            if (frame_end) begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q     <= 3'd0;
            pclk_en_q <= 1'b0;
            posh_q    <= H_BASE_9;
            posv_q    <= 9'd0;
            hblk_q    <= 1'b1;
            vblk_q    <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            vbirq_q   <= 1'b0;
            frame_q   <= 8'd0;
            hofs_q    <= 4'd0;
            vofs_q    <= 4'd0;
        end else begin
            div_q     <= div_d;
            pclk_en_q <= pclk_en_d;
            posh_q    <= posh_d;
            posv_q    <= posv_d;
            hblk_q    <= hblk_d;
            vblk_q    <= vblk_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            vbirq_q   <= vbirq_d;
            frame_q   <= frame_d;
            hofs_q    <= hofs_d;
            vofs_q    <= vofs_d;
        end
    end

    assign PCLK_EN = pclk_en_q;
    assign POSH    = posh_q;
    assign POSV    = posv_q;
    assign HBLK    = hblk_q;
    assign VBLK    = vblk_q;
    assign HSYNC   = hsync_q;
    assign VSYNC   = vsync_q;
    assign VBIRQ   = vbirq_q;
    assign FRAME   = frame_q;

endmodule

// File: tb/tb_digdug_hvgen.sv
// Bench for digdug_hvgen: a shrunken-raster instance checked every cycle against a
// closed-form timing model, plus a default-parameter instance checked over one line.
module tb_digdug_hvgen;

    localparam int CD  = 2;
    localparam int HB  = 496;
    localparam int VT  = 8;
    localparam int HBF = 498;
    localparam int HBN = 508;
    localparam int HSN = 502;
    localparam int HSF = 505;
    localparam int VBN = 5;
    localparam int VSN = 6;
    localparam int VSF = 7;
    localparam int HL  = 512 - HB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       rst_def_n = 1'b0;
    logic [3:0] hofs = 4'd0;
    logic [3:0] vofs = 4'd0;

    logic       pclk_en, hblk, vblk, hsync, vsync, vbirq;
    logic [8:0] posh, posv;
    logic [7:0] frame;

    logic       d_pclk_en, d_hblk, d_vblk, d_hsync, d_vsync, d_vbirq;
    logic [8:0] d_posh, d_posv;
    logic [7:0] d_frame;

    digdug_hvgen #(
        .CLK_DIV(CD), .H_BASE(HB), .V_TOTAL(VT), .HBLK_OFF(HBF), .HBLK_ON(HBN),
        .HS_ON(HSN), .HS_OFF(HSF), .VBLK_ON(VBN), .VS_ON(VSN), .VS_OFF(VSF)
    ) dut (
        .CLK48M(clk), .RESET_N(rst_n), .HOFS(hofs), .VOFS(vofs),
        .PCLK_EN(pclk_en), .POSH(posh), .POSV(posv), .HBLK(hblk), .VBLK(vblk),
        .HSYNC(hsync), .VSYNC(vsync), .VBIRQ(vbirq), .FRAME(frame)
    );

    digdug_hvgen u_def (
        .CLK48M(clk), .RESET_N(rst_def_n), .HOFS(4'd0), .VOFS(4'd0),
        .PCLK_EN(d_pclk_en), .POSH(d_posh), .POSV(d_posv), .HBLK(d_hblk), .VBLK(d_vblk),
        .HSYNC(d_hsync), .VSYNC(d_vsync), .VBIRQ(d_vbirq), .FRAME(d_frame)
    );

    int tests = 0;
    int fails = 0;
    bit done = 1'b0;
    bit def_done = 1'b0;
    bit cmp_en = 1'b0;

    task automatic finish_tb();
        if (!done) begin
            done = 1'b1;
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
            if (fails >= 40) finish_tb();
        end
    endtask

    // ---------------- behavioural model: everything follows from edges since release
    int t = 0;
    int m_hs = 0;
    int m_vs = 0;

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int ticks(input int tt);
        return (tt >= 1) ? (tt - 1) / CD : 0;
    endfunction

    function automatic bit tick_edge(input int tt);
        return (tt > CD) && ((tt - 1) % CD == 0);
    endfunction

    always @(posedge clk) begin
        automatic int tn = t + 1;
        if (!rst_n) begin
            t    <= 0;
            m_hs <= 0;
            m_vs <= 0;
        end else begin
            t <= tn;
            if (tick_edge(tn) && (ticks(tn) % (HL * VT) == 0)) begin
                m_hs <= sx4(hofs);
                m_vs <= sx4(vofs);
            end
        end
    end

    task automatic compare();
        int tt, p, px, eh, ev;
        tt = rst_n ? t : 0;
        p  = ticks(tt);
        px = p % HL;
        eh = HB + px;
        ev = (p / HL) % VT;
        chk("pclk_en", int'(pclk_en), int'(tt >= CD && tt % CD == 0));
        chk("posh", int'(posh), eh);
        chk("posv", int'(posv), ev);
        chk("frame", int'(frame), (p / (HL * VT)) % 256);
        chk("hblk", int'(hblk), int'(eh >= HBN || eh < HBF));
        chk("vblk", int'(vblk), int'(ev >= VBN));
        chk("hsync", int'(hsync), int'(eh >= HSN + m_hs && eh < HSF + m_hs));
        chk("vsync", int'(vsync), int'(ev >= VSN + m_vs && ev < VSF + m_vs));
        chk("vbirq", int'(vbirq), int'(tick_edge(tt) && px == 0 && ev == VBN));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (cmp_en) compare();
    end

    task automatic wait_pos(input int h, input int v, input string nm);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge clk);
            n++;
            hit = (h < 0 || int'(posh) == h) && (v < 0 || int'(posv) == v);
        end
        chk(nm, int'(hit), 1);
    endtask

    // ---------------- default-parameter instance: reset release and one full line
    initial begin
        int first = 0;
        int npclk = 0, nhblk = 0, nhs = 0, nvb = 0, hs_first = -1, n = 0;
        repeat (3) @(negedge clk);
        rst_def_n = 1'b1;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            @(negedge clk);
            if (d_pclk_en) begin
                first = i;
                chk("def_posh_at_first_pclk", int'(d_posh), 128);
                chk("def_posv_at_first_pclk", int'(d_posv), 0);
                chk("def_hblk_at_first_pclk", int'(d_hblk), 1);
                chk("def_frame_at_first_pclk", int'(d_frame), 0);
            end
        end
        chk("def_first_pclk_cycle", first, 8);
        while (d_posv != 9'd2 && n < 8000) begin
            @(negedge clk);
            n++;
            if (d_posv == 9'd1 && d_pclk_en) begin
                npclk++;
                if (d_hblk) nhblk++;
                if (d_hsync) begin
                    nhs++;
                    if (hs_first < 0) hs_first = int'(d_posh);
                end
                if (d_vblk || d_vsync) nvb++;
            end
        end
        chk("def_line_reached", int'(d_posv), 2);
        chk("def_pclk_per_line", npclk, 384);
        chk("def_hblk_px", nhblk, 96);
        chk("def_hsync_px", nhs, 32);
        chk("def_hsync_start", hs_first, 448);
        chk("def_vblk_vsync_line1", nvb, 0);
        def_done = 1'b1;
    end

    // ---------------- main stimulus on the shrunken raster
    initial begin
        int vb, pv, n;
        bit seen;
        logic [7:0] pf;

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rel_pclk_e1", int'(pclk_en), 0);
        @(negedge clk);
        chk("rel_pclk_e2", int'(pclk_en), 1);
        chk("rel_posh_e2", int'(posh), 496);
        chk("rel_hblk_e2", int'(hblk), 1);
        chk("rel_frame_e2", int'(frame), 0);
        @(negedge clk);
        chk("rel_posh_e3", int'(posh), 497);

        // offsets +3 / -2 applied mid-frame
        wait_pos(-1, 2, "wait_mid_frame");
        hofs = 4'd3;
        vofs = 4'hE;
        wait_pos(502, 3, "wait_h502_cur");
        chk("cur_hsync_502", int'(hsync), 1);
        wait_pos(505, 3, "wait_h505_cur");
        chk("cur_hsync_505", int'(hsync), 0);
        wait_pos(-1, 4, "wait_v4_cur");
        chk("cur_vsync_4", int'(vsync), 0);
        wait_pos(-1, 6, "wait_v6_cur");
        chk("cur_vsync_6", int'(vsync), 1);
        wait_pos(504, 0, "wait_h504_nxt");
        chk("nxt_hsync_504", int'(hsync), 0);
        wait_pos(505, 0, "wait_h505_nxt");
        chk("nxt_hsync_505", int'(hsync), 1);
        wait_pos(507, 0, "wait_h507_nxt");
        chk("nxt_hsync_507", int'(hsync), 1);
        wait_pos(508, 0, "wait_h508_nxt");
        chk("nxt_hsync_508", int'(hsync), 0);
        wait_pos(-1, 4, "wait_v4_nxt");
        chk("nxt_vsync_4", int'(vsync), 1);
        wait_pos(-1, 5, "wait_v5_nxt");
        chk("nxt_vsync_5", int'(vsync), 0);

        // random offset changes at random moments
        for (int k = 0; k < 50; k++) begin
            repeat ($urandom_range(20, 200)) @(negedge clk);
            hofs = 4'($urandom_range(0, 8) - 4);
            vofs = 4'($urandom_range(0, 4) - 3);
        end

        // asynchronous reset mid-line, mid-frame
        wait_pos(503, 3, "wait_reset_point");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_posh", int'(posh), 496);
        chk("arst_posv", int'(posv), 0);
        chk("arst_pclk", int'(pclk_en), 0);
        chk("arst_hblk", int'(hblk), 1);
        chk("arst_frame", int'(frame), 0);
        chk("arst_vbirq", int'(vbirq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_pclk_e1", int'(pclk_en), 0);
        @(negedge clk);
        chk("rst2_pclk_e2", int'(pclk_en), 1);

        // run until the frame counter wraps 255 -> 0
        vb   = 0;
        seen = 1'b0;
        pf   = frame;
        pv   = int'(posv);
        n    = 0;
        while (!seen && n < 70000) begin
            @(negedge clk);
            n++;
            if (vbirq && frame >= 8'd1 && frame <= 8'd254) vb++;
            if (frame != pf) begin
                if (pf == 8'd255) begin
                    seen = 1'b1;
                    chk("wrap_frame", int'(frame), 0);
                    chk("wrap_posv", int'(posv), 0);
                    chk("wrap_posh", int'(posh), 496);
                    chk("wrap_prev_posv", pv, VT - 1);
                end
                pf = frame;
            end
            pv = int'(posv);
        end
        chk("frame_wrap_seen", int'(seen), 1);
        chk("vbirq_per_frame", vb, 254);

        n = 0;
        while (!def_done && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("def_instance_done", int'(def_done), 1);
        finish_tb();
    end

endmodule
